// File: rtl/array_guard_pkg.sv
// Shared constants for the guarded array read path: error codes, the
// response-buffer state encoding and a saturating counter helper.
package array_guard_pkg;

    // Error codes reported alongside every read response.
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_UNDEF = 2'b10;

    // Response buffer occupancy states.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Increment an 8-bit count, holding at the maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end
        return value + 8'd1;
    endfunction

endpackage

// File: rtl/array_rd_guard_if.sv
// Bus bundle for the guarded array: write port, read request and read
// response handshakes, plus the error counter.
interface array_rd_guard_if #(
    parameter int WIDTH = 2,
    parameter int AW    = 4
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [AW-1:0]    rd_addr;

    logic             rd_rsp_valid;
    logic             rd_rsp_ready;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       rd_err;
    logic [7:0]       err_cnt;

    // Requester / consumer side.
    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_req_valid, rd_addr,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_data, rd_err, err_cnt,
        output rd_rsp_ready
    );

    // Array side.
    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_req_valid, rd_addr,
        output rd_req_ready,
        output rd_rsp_valid, rd_data, rd_err, err_cnt,
        input  rd_rsp_ready
    );
endinterface

// File: rtl/rsp_skid_buf.sv
// Two-entry in-order response buffer. Ready towards the producer depends
// only on the registered state, so no combinational path runs from the
// consumer's ready back to the producer.
module rsp_skid_buf
    import array_guard_pkg::*;
#(
    parameter int            PW      = 4,
    parameter logic [PW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push_valid,
    output logic          o_push_ready,
    input  logic [PW-1:0] i_push_data,
    output logic          o_pop_valid,
    input  logic          i_pop_ready,
    output logic [PW-1:0] o_pop_data
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] w_head_next;
    logic [PW-1:0] w_tail_next;
    logic          w_push;
    logic          w_pop;

    assign o_push_ready = (r_state != ST_TWO);
    assign o_pop_valid  = (r_state != ST_EMPTY);
    assign o_pop_data   = r_head;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    // Next occupancy and entry contents; head is always the oldest response.
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_head_next  = i_push_data;
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_next = i_push_data;
                end else if (w_push) begin
                    w_tail_next  = i_push_data;
                    w_state_next = ST_TWO;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Producer is stalled here, so only a pop can happen.
                if (w_pop) begin
                    w_head_next  = r_tail;
                    w_state_next = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset drops anything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= RST_VAL;
            r_tail  <= RST_VAL;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
        end
    end

endmodule

// File: rtl/array_rd_guard.sv
// Register array indexed over [HI:LO] with a plain write port and a
// handshaked read port. Out-of-range or unknown indices never touch
// storage: writes are dropped silently, reads return DFLT plus an error code.
module array_rd_guard
    import array_guard_pkg::*;
#(
    parameter int               WIDTH = 2,
    parameter int               LO    = 1,
    parameter int               HI    = 2,
    parameter int               AW    = 4,
    parameter logic [WIDTH-1:0] DFLT  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    array_rd_guard_if.slave       bus
);

    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] w_mem [LO:HI];
    logic [WIDTH-1:0] w_rd_word;
    logic [1:0]       w_rd_err;
    logic [PW-1:0]    w_rd_payload;
    logic [PW-1:0]    w_rsp_payload;
    logic             w_wr_ok;
    logic             w_rd_accept;
    logic [7:0]       r_err_cnt;

    // A write is only honoured when the whole index is known.
    assign w_wr_ok = bus.wr_en && !$isunknown(bus.wr_addr);

    generate
        for (genvar gi = LO; gi <= HI; gi++) begin : g_entry
            logic [WIDTH-1:0] r_word;

            // One storage entry; updates only on a write that hits this index.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (w_wr_ok && (bus.wr_addr == AW'(gi))) begin
                    r_word <= bus.wr_data;
                end
            end

            assign w_mem[gi] = r_word;
        end
    endgenerate

    // Select the addressed entry from the current contents, so a write in
    // the same cycle is not yet visible (read-before-write).
    always_comb begin
        w_rd_word = DFLT;
        for (int k = LO; k <= HI; k++) begin
            if (bus.rd_addr == AW'(k)) begin
                w_rd_word = w_mem[k];
            end
        end
    end

    // Classify the read index; an unknown index takes precedence over range.
    always_comb begin
        if ($isunknown(bus.rd_addr)) begin
            w_rd_err = ERR_UNDEF;
        end else if ((bus.rd_addr < AW'(LO)) || (bus.rd_addr > AW'(HI))) begin
            w_rd_err = ERR_RANGE;
        end else begin
            w_rd_err = ERR_OK;
        end
    end

    assign w_rd_payload = {w_rd_err, (w_rd_err == ERR_OK) ? w_rd_word : DFLT};
    assign w_rd_accept  = bus.rd_req_valid && bus.rd_req_ready;

    rsp_skid_buf #(
        .PW      (PW),
        .RST_VAL ({ERR_OK, DFLT})
    ) u_rsp_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (bus.rd_req_valid),
        .o_push_ready (bus.rd_req_ready),
        .i_push_data  (w_rd_payload),
        .o_pop_valid  (bus.rd_rsp_valid),
        .i_pop_ready  (bus.rd_rsp_ready),
        .o_pop_data   (w_rsp_payload)
    );

    assign bus.rd_err  = w_rsp_payload[PW-1 -: 2];
    assign bus.rd_data = w_rsp_payload[WIDTH-1:0];

    // Count accepted errored reads, holding at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_rd_accept && (w_rd_err != ERR_OK)) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end
    end

    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_array_rd_guard.sv
// Directed bench for array_rd_guard: a queue/array model of the read path
// checked every cycle, plus literal expectations at key points.
module tb_array_rd_guard;
    import array_guard_pkg::*;

    localparam int               WIDTH = 2;
    localparam int               LO    = 1;
    localparam int               HI    = 2;
    localparam int               AW    = 4;
    localparam logic [WIDTH-1:0] DFLT  = 2'd0;

    logic clk = 1'b0;
    logic rst_n;

    array_rd_guard_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    array_rd_guard #(
        .WIDTH(WIDTH), .LO(LO), .HI(HI), .AW(AW), .DFLT(DFLT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0]   m_mem [LO:HI];
    logic [WIDTH+1:0]   m_q [$];
    int                 m_cnt = 0;
    bit                 m_live = 1'b0;

    always @(posedge clk) begin
        int        sz;
        bit        acc;
        bit        pop;
        logic [1:0] e;
        logic [WIDTH-1:0] d;
        sz  = m_q.size();
        acc = (bus.rd_req_valid === 1'b1) && (sz < 2);
        pop = (sz > 0) && (bus.rd_rsp_ready === 1'b1);
        if (rst_n !== 1'b1) begin
            m_q.delete();
            m_cnt = 0;
            for (int k = LO; k <= HI; k++) m_mem[k] = '0;
            m_live = 1'b1;
        end else begin
            if (acc) begin
                if ($isunknown(bus.rd_addr)) e = ERR_UNDEF;
                else if (int'(bus.rd_addr) < LO || int'(bus.rd_addr) > HI) e = ERR_RANGE;
                else e = ERR_OK;
                d = (e == ERR_OK) ? m_mem[int'(bus.rd_addr)] : DFLT;
                if (e != ERR_OK && m_cnt < 255) m_cnt++;
            end
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back({e, d});
            if (bus.wr_en === 1'b1 && !$isunknown(bus.wr_addr) &&
                int'(bus.wr_addr) >= LO && int'(bus.wr_addr) <= HI)
                m_mem[int'(bus.wr_addr)] = bus.wr_data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live && rst_n === 1'b1) begin
            chk("rsp_valid", 32'(bus.rd_rsp_valid), 32'(m_q.size() > 0));
            chk("req_ready", 32'(bus.rd_req_ready), 32'(m_q.size() < 2));
            chk("err_cnt",   32'(bus.err_cnt),      32'(m_cnt));
            if (m_q.size() > 0) begin
                chk("rd_data", 32'(bus.rd_data), 32'(m_q[0][WIDTH-1:0]));
                chk("rd_err",  32'(bus.rd_err),  32'(m_q[0][WIDTH+1:WIDTH]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_rsp(input string name, input logic [1:0] d, input logic [1:0] e);
        chk({name, "_valid"}, 32'(bus.rd_rsp_valid), 32'd1);
        chk({name, "_data"},  32'(bus.rd_data),      32'(d));
        chk({name, "_err"},   32'(bus.rd_err),       32'(e));
        $display("rsp %s: data=%0d err=%0b cnt=%0d", name, bus.rd_data, bus.rd_err, bus.err_cnt);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_addr      = '0;
        bus.rd_rsp_ready = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", 32'(bus.rd_rsp_valid), 32'd0);
        chk("rst_data",  32'(bus.rd_data),      32'(DFLT));
        chk("rst_err",   32'(bus.rd_err),       32'd0);
        chk("rst_cnt",   32'(bus.err_cnt),      32'd0);
        chk("rst_ready", 32'(bus.rd_req_ready), 32'd1);
        $display("reset released");

        // Legal writes, then reads back
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 2'd3; cycle();
        $display("write idx2=3");
        bus.wr_addr = 4'd1; bus.wr_data = 2'd1; cycle();
        $display("write idx1=1");
        bus.wr_en = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 4'd2;
        chk("lat_pre", 32'(bus.rd_rsp_valid), 32'd0);
        cycle();
        lit_rsp("rd2", 2'd3, ERR_OK);
        bus.rd_addr = 4'd1; cycle();
        lit_rsp("rd1", 2'd1, ERR_OK);
        bus.rd_req_valid = 1'b0; cycle();
        chk("idle_valid", 32'(bus.rd_rsp_valid), 32'd0);

        // Out-of-range writes are dropped; out-of-range read errors
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 2'd1; cycle();
        bus.wr_addr = 4'd3; cycle();
        $display("write idx0,idx3 (dropped)");
        bus.wr_en = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 4'd2; cycle();
        lit_rsp("keep2", 2'd3, ERR_OK);
        bus.rd_addr = 4'd1; cycle();
        lit_rsp("keep1", 2'd1, ERR_OK);
        bus.rd_addr = 4'd3; cycle();
        lit_rsp("oor3", 2'd0, ERR_RANGE);
        chk("oor_cnt", 32'(bus.err_cnt), 32'd1);

        // Unknown index read
        bus.rd_addr = 'x; cycle();
        chk("undef_data", 32'(bus.rd_data), 32'(DFLT));
        chk("undef_err_nz", 32'(bus.rd_err != ERR_OK), 32'd1);
        chk("undef_cnt", 32'(bus.err_cnt), 32'd2);
        $display("rsp undef: data=%0d err=%0b cnt=%0d", bus.rd_data, bus.rd_err, bus.err_cnt);
        bus.rd_addr = 4'd1; cycle();
        lit_rsp("after_undef", 2'd1, ERR_OK);
        bus.rd_req_valid = 1'b0; cycle();

        // Backpressure: two buffered, ready drops, drain in order
        bus.rd_rsp_ready = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 4'd2; cycle();
        chk("bp1_ready", 32'(bus.rd_req_ready), 32'd1);
        bus.rd_addr = 4'd1; cycle();
        chk("bp2_ready", 32'(bus.rd_req_ready), 32'd0);
        bus.rd_addr = 4'd2; cycle();
        lit_rsp("bp_hold", 2'd3, ERR_OK);
        chk("bp3_ready", 32'(bus.rd_req_ready), 32'd0);
        bus.rd_req_valid = 1'b0; bus.rd_rsp_ready = 1'b1; cycle();
        lit_rsp("bp_drain2", 2'd1, ERR_OK);
        chk("drain_ready", 32'(bus.rd_req_ready), 32'd1);
        cycle();
        chk("drain_empty", 32'(bus.rd_rsp_valid), 32'd0);

        // Same-cycle write and read of idx1: old value first
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 2'd2;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 4'd1; cycle();
        lit_rsp("rbw_old", 2'd1, ERR_OK);
        bus.wr_en = 1'b0; cycle();
        lit_rsp("rbw_new", 2'd2, ERR_OK);

        // Saturation over 300 errored reads
        bus.rd_addr = 4'd3;
        for (int i = 0; i < 300; i++) cycle();
        chk("sat_cnt", 32'(bus.err_cnt), 32'd255);
        $display("after 300 errored reads cnt=%0d", bus.err_cnt);

        // Reset with responses pending
        bus.rd_rsp_ready = 1'b0; bus.rd_addr = 4'd2; cycle();
        bus.rd_req_valid = 1'b0;
        chk("pend_valid", 32'(bus.rd_rsp_valid), 32'd1);
        rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.rd_rsp_valid), 32'd0);
        chk("mid_rst_cnt",   32'(bus.err_cnt),      32'd0);
        chk("mid_rst_data",  32'(bus.rd_data),      32'(DFLT));
        $display("mid-operation reset applied");
        bus.rd_rsp_ready = 1'b1;
        bus.rd_req_valid = 1'b1; bus.rd_addr = 4'd2; cycle();
        lit_rsp("cleared2", 2'd0, ERR_OK);
        bus.rd_req_valid = 1'b0; cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
